// File: rtl/mem_port_scheduler.sv
// Shared RAM read-port scheduler between IF and MEM: combinational grant, a run
// limit on MEM while IF waits, one-cycle return steering and a stall counter.
//
// state    | meaning
// IF_OWN   | grant_mem=0, IF drives the RAM address, run_cnt cleared
// MEM_OWN  | grant_mem=1, run_cnt < MAX_MEM_RUN (or no IF requester)
// FORCE_IF | IF_Req & MEM_RdReq & run_cnt==MAX_MEM_RUN, IF forced in, MEM waits
module mem_port_scheduler #(
  parameter int          MAX_MEM_RUN = 4,
  parameter int          DATA_W      = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              gclk,
  input  logic              rst_n,
  input  logic              IF_Req,
  input  logic              IF_Flush,
  input  logic              MEM_RdReq,
  output logic              RAM_AddrSel,
  output logic              IF_DataSel,
  output logic [DATA_W-1:0] MEM_IFBypassData,
  output logic              IF_Stall,
  output logic              MEM_Wait,
  output logic              MEM_RdValid,
  output logic [15:0]       StallCnt
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_MEM_RUN);

  logic [3:0] run_cnt;
  logic       run_at_max;
  logic       grant_mem;

  assign run_at_max  = (run_cnt == RUN_MAX);
  assign grant_mem   = MEM_RdReq & ~(IF_Req & run_at_max);
  assign RAM_AddrSel = grant_mem;
  assign IF_Stall    = IF_Req & grant_mem;
  assign MEM_Wait    = MEM_RdReq & ~grant_mem;

  // MEM runs only count against the limit while IF is actually waiting.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= 4'd0;
    end else if (!grant_mem) begin
      run_cnt <= 4'd0;
    end else if (IF_Req) begin
      run_cnt <= run_cnt + 4'd1;
    end
  end

  // Steering flags line up with the RAM read data one cycle after the address.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_RdValid      <= 1'b0;
      IF_DataSel       <= 1'b0;
      MEM_IFBypassData <= NOP_WORD;
    end else begin
      MEM_RdValid      <= grant_mem;
      IF_DataSel       <= grant_mem | IF_Flush;
      MEM_IFBypassData <= NOP_WORD;
    end
  end

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt <= 16'd0;
    end else if (IF_Stall && (StallCnt != 16'hFFFF)) begin
      StallCnt <= StallCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed testbench for mem_port_scheduler with MAX_MEM_RUN=4 and NOP_WORD=0.
module tb_mem_port_scheduler;

  localparam logic [15:0] NOP = 16'h0000;

  logic        gclk = 1'b0;
  logic        rst_n;
  logic        IF_Req, IF_Flush, MEM_RdReq;
  logic        RAM_AddrSel, IF_DataSel, IF_Stall, MEM_Wait, MEM_RdValid;
  logic [15:0] MEM_IFBypassData, StallCnt;

  int tests  = 0;
  int failed = 0;

  always #5 gclk = ~gclk;

  mem_port_scheduler #(.MAX_MEM_RUN(4), .DATA_W(16), .NOP_WORD(16'h0000)) dut (
    .gclk(gclk), .rst_n(rst_n), .IF_Req(IF_Req), .IF_Flush(IF_Flush),
    .MEM_RdReq(MEM_RdReq), .RAM_AddrSel(RAM_AddrSel), .IF_DataSel(IF_DataSel),
    .MEM_IFBypassData(MEM_IFBypassData), .IF_Stall(IF_Stall), .MEM_Wait(MEM_Wait),
    .MEM_RdValid(MEM_RdValid), .StallCnt(StallCnt)
  );

  // Inputs change at the falling edge; registered outputs then show the previous cycle.
  task automatic drive(input logic ifr, input logic flush, input logic memr);
    @(negedge gclk);
    IF_Req = ifr; IF_Flush = flush; MEM_RdReq = memr;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; IF_Req = 1'b0; IF_Flush = 1'b0; MEM_RdReq = 1'b0;
    @(negedge gclk); @(negedge gclk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1, 0, 1); drive(1, 0, 1); drive(1, 0, 1);
    @(posedge gclk); #2;
    rst_n = 1'b0; #1;
    tests++; if (IF_DataSel !== 1'b0) begin failed++; $display("FAIL reset_datasel got %b want 0", IF_DataSel); end
    tests++; if (MEM_RdValid !== 1'b0) begin failed++; $display("FAIL reset_rdvalid got %b want 0", MEM_RdValid); end
    tests++; if (StallCnt !== 16'd0) begin failed++; $display("FAIL reset_stallcnt got %h want 0000", StallCnt); end
    tests++; if (MEM_IFBypassData !== NOP) begin failed++; $display("FAIL reset_bypass got %h want %h", MEM_IFBypassData, NOP); end
    tests++; if (RAM_AddrSel !== 1'b1) begin failed++; $display("FAIL reset_comb_addrsel got %b want 1", RAM_AddrSel); end
    @(posedge gclk); #1;
    drive(1, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) drive(1, 0, 0);
      tests++; if (RAM_AddrSel !== 1'b0 || IF_Stall !== 1'b0) begin
        failed++; $display("FAIL post_reset_if cyc %0d addrsel %b stall %b want 0 0", i, RAM_AddrSel, IF_Stall);
      end
      tests++; if (MEM_RdValid !== 1'b0) begin failed++; $display("FAIL post_reset_rdvalid cyc %0d got %b want 0", i, MEM_RdValid); end
    end
  endtask

  task automatic test_single_load();
    do_reset();
    for (int c = 1; c <= 4; c++) drive(1, 0, 0);
    drive(1, 0, 1);
    tests++; if (RAM_AddrSel !== 1'b1 || IF_Stall !== 1'b1 || MEM_Wait !== 1'b0) begin
      failed++; $display("FAIL load_c5 addrsel %b stall %b wait %b want 1 1 0", RAM_AddrSel, IF_Stall, MEM_Wait);
    end
    drive(1, 0, 0);
    tests++; if (MEM_RdValid !== 1'b1 || IF_DataSel !== 1'b1 || MEM_IFBypassData !== NOP) begin
      failed++; $display("FAIL load_c6 rdvalid %b datasel %b bypass %h want 1 1 %h", MEM_RdValid, IF_DataSel, MEM_IFBypassData, NOP);
    end
    tests++; if (RAM_AddrSel !== 1'b0 || IF_Stall !== 1'b0) begin
      failed++; $display("FAIL load_c6_comb addrsel %b stall %b want 0 0", RAM_AddrSel, IF_Stall);
    end
    drive(1, 0, 0);
    tests++; if (MEM_RdValid !== 1'b0 || IF_DataSel !== 1'b0 || IF_Stall !== 1'b0 || RAM_AddrSel !== 1'b0) begin
      failed++; $display("FAIL load_c7 rdvalid %b datasel %b stall %b addrsel %b want 0 0 0 0", MEM_RdValid, IF_DataSel, IF_Stall, RAM_AddrSel);
    end
    tests++; if (StallCnt !== 16'd1) begin failed++; $display("FAIL load_stallcnt got %0d want 1", StallCnt); end
  endtask

  task automatic test_starvation();
    logic exp_g, prev_g;
    do_reset();
    drive(1, 0, 0);
    prev_g = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      exp_g = ((c % 5) != 0);
      drive(1, 0, 1);
      tests++; if (RAM_AddrSel !== exp_g || MEM_Wait !== ~exp_g || IF_Stall !== exp_g) begin
        failed++; $display("FAIL starve_c%0d addrsel %b wait %b stall %b want %b %b %b", c, RAM_AddrSel, MEM_Wait, IF_Stall, exp_g, ~exp_g, exp_g);
      end
      tests++; if (MEM_RdValid !== prev_g || IF_DataSel !== prev_g) begin
        failed++; $display("FAIL starve_ret_c%0d rdvalid %b datasel %b want %b", c, MEM_RdValid, IF_DataSel, prev_g);
      end
      prev_g = exp_g;
    end
    drive(1, 0, 0);
    tests++; if (StallCnt !== 16'd10) begin failed++; $display("FAIL starve_stallcnt got %0d want 10", StallCnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1);
      tests++; if (MEM_Wait !== 1'b0 || IF_Stall !== 1'b0 || RAM_AddrSel !== 1'b1) begin
        failed++; $display("FAIL b2b_c%0d wait %b stall %b addrsel %b want 0 0 1", i, MEM_Wait, IF_Stall, RAM_AddrSel);
      end
      if (i > 0) begin
        tests++; if (MEM_RdValid !== 1'b1 || IF_DataSel !== 1'b1) begin
          failed++; $display("FAIL b2b_ret_c%0d rdvalid %b datasel %b want 1 1", i, MEM_RdValid, IF_DataSel);
        end
      end
    end
    drive(1, 0, 0);
    tests++; if (StallCnt !== 16'd10 || MEM_RdValid !== 1'b1) begin
      failed++; $display("FAIL b2b_end stallcnt %0d rdvalid %b want 10 1", StallCnt, MEM_RdValid);
    end
    drive(1, 0, 0);
    tests++; if (IF_DataSel !== 1'b0 || MEM_RdValid !== 1'b0) begin
      failed++; $display("FAIL b2b_regain datasel %b rdvalid %b want 0 0", IF_DataSel, MEM_RdValid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 1, 1);
    drive(1, 0, 0);
    tests++; if (IF_DataSel !== 1'b1 || MEM_RdValid !== 1'b1) begin
      failed++; $display("FAIL flush_collide datasel %b rdvalid %b want 1 1", IF_DataSel, MEM_RdValid);
    end
    drive(1, 1, 0);
    tests++; if (IF_DataSel !== 1'b0) begin failed++; $display("FAIL flush_gap datasel %b want 0", IF_DataSel); end
    drive(1, 0, 0);
    tests++; if (IF_DataSel !== 1'b1 || MEM_RdValid !== 1'b0 || MEM_IFBypassData !== NOP) begin
      failed++; $display("FAIL flush_alone datasel %b rdvalid %b bypass %h want 1 0 %h", IF_DataSel, MEM_RdValid, MEM_IFBypassData, NOP);
    end
    drive(1, 0, 0);
    tests++; if (IF_DataSel !== 1'b0 || StallCnt !== 16'd1) begin
      failed++; $display("FAIL flush_after datasel %b stallcnt %0d want 0 1", IF_DataSel, StallCnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 16383; n++) begin
      for (int k = 0; k < 4; k++) drive(1, 0, 1);
      drive(1, 0, 0);
    end
    drive(1, 0, 1); drive(1, 0, 1);
    drive(1, 0, 0);
    tests++; if (StallCnt !== 16'hFFFE) begin failed++; $display("FAIL sat_preload got %h want fffe", StallCnt); end
    for (int k = 0; k < 3; k++) drive(1, 0, 1);
    drive(1, 0, 0);
    tests++; if (StallCnt !== 16'hFFFF) begin failed++; $display("FAIL sat_reach got %h want ffff", StallCnt); end
    for (int k = 0; k < 3; k++) drive(1, 0, 1);
    drive(0, 0, 0);
    tests++; if (StallCnt !== 16'hFFFF) begin failed++; $display("FAIL sat_hold got %h want ffff", StallCnt); end
  endtask

  initial begin
    rst_n = 1'b0; IF_Req = 1'b0; IF_Flush = 1'b0; MEM_RdReq = 1'b0;
    test_reset();
    test_single_load();
    test_starvation();
    test_back_to_back();
    test_flush();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
